// File: rtl/trace_ctrl_pkg.sv
// Shared constants for trace_ctrl: command/reply bytes, FSM encoding and flag-byte layout.
package trace_ctrl_pkg;

  localparam logic [7:0] CMD_WIDTH  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_EN     = 8'h45;  // 'E'
  localparam logic [7:0] CMD_DIS    = 8'h44;  // 'D'
  localparam logic [7:0] CMD_QUERY  = 8'h3F;  // '?'

  localparam logic [7:0] RSP_STATUS = 8'h53;  // 'S'
  localparam logic [7:0] RSP_ERR    = 8'h21;  // '!'
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam int FLAG_EN    = 0;
  localparam int FLAG_DROP  = 1;
  localparam int FLAG_RXERR = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARG,
    ST_REPLY0,
    ST_REPLY1,
    ST_REPLY2
  } state_t;

  // Decodes an ASCII width argument; 0 marks anything that is not '1', '2' or '4'.
  function automatic logic [2:0] arg_width(input logic [7:0] b);
    case (b)
      8'h31:   return 3'd1;
      8'h32:   return 3'd2;
      8'h34:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/trace_ctrl_led_stretch.sv
// Single-bit retriggerable pulse stretcher: an event holds the output high for STRETCH_CYCLES cycles.
module led_stretch #(
  parameter int STRETCH_CYCLES = 2_400_000
) (
  input  logic clkOut,
  input  logic rst,
  input  logic evt,
  output logic led
);

  localparam int CW = (STRETCH_CYCLES > 2) ? $clog2(STRETCH_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          led_q, led_d;

  always_comb begin
    cnt_d = cnt_q;
    if (evt) begin
      cnt_d = CW'(STRETCH_CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
    led_d = (cnt_q != '0) || evt;
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      cnt_q <= '0;
      led_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      led_q <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/trace_ctrl.sv
// Trace probe runtime control: UART command parser, status replies, LED stretchers and heartbeat.
// Optional argument-byte timeout is compiled in with `define TRACE_CTRL_TIMEOUT_EN.
module trace_ctrl
  import trace_ctrl_pkg::*;
#(
  parameter int CLK_FREQ       = 48_000_000,
  parameter int HEARTBEAT_HZ   = 1,
  parameter int NUM_LEDS       = 4,
  parameter int STRETCH_CYCLES = 2_400_000,
  parameter int MAX_BUS_WIDTH  = 4,
  parameter int TIMEOUT_CYCLES = 4_800_000
) (
  input  logic                clkOut,
  input  logic                rst,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  input  logic                rx_err,
  output logic [7:0]          tx_byte,
  output logic                tx_valid,
  input  logic                tx_free,
  output logic [2:0]          width,
  output logic                width_chg,
  output logic                trace_en,
  output logic                cmd_err,
  input  logic [NUM_LEDS-1:0] led_evt,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                heartbeat
);

  localparam int HB_TC  = CLK_FREQ / (2 * HEARTBEAT_HZ);
  localparam int HBW    = (HB_TC > 2) ? $clog2(HB_TC) : 1;

  state_t      state_q, state_d;
  logic [2:0]  width_q, width_d;
  logic        trace_en_q, trace_en_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        tx_valid_q, tx_valid_d;
  logic        width_chg_q, width_chg_d;
  logic        cmd_err_q, cmd_err_d;
  logic        err_reply_q, err_reply_d;
  logic        drop_q, drop_d;
  logic        rxerr_q, rxerr_d;
  logic [HBW-1:0] hb_cnt_q, hb_cnt_d;
  logic        hb_q, hb_d;

  logic [2:0]  arg_w;
  logic        arg_ok;
  logic        tx_done;
  logic        in_reply;
  logic        drop_set;
  logic        sticky_clr;

  assign arg_w    = arg_width(rx_byte);
  assign arg_ok   = (arg_w != 3'd0) && (int'(arg_w) <= MAX_BUS_WIDTH);
  assign tx_done  = tx_valid_q && tx_free;
  assign in_reply = (state_q == ST_REPLY0) || (state_q == ST_REPLY1) || (state_q == ST_REPLY2);
  assign drop_set = rx_valid && in_reply;

`ifdef TRACE_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  assign to_cnt_d = (state_q == ST_ARG) ? to_cnt_q + TW'(1) : '0;

  always_ff @(posedge clkOut) begin
    if (rst) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    trace_en_d  = trace_en_q;
    tx_byte_d   = tx_byte_q;
    tx_valid_d  = tx_valid_q;
    width_chg_d = 1'b0;
    cmd_err_d   = 1'b0;
    err_reply_d = err_reply_q;
    sticky_clr  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_byte)
            CMD_WIDTH: state_d    = ST_ARG;
            CMD_EN:    trace_en_d = 1'b1;
            CMD_DIS:   trace_en_d = 1'b0;
            CMD_QUERY: begin
              state_d     = ST_REPLY0;
              tx_byte_d   = RSP_STATUS;
              tx_valid_d  = 1'b1;
              err_reply_d = 1'b0;
            end
            default: begin
              state_d     = ST_REPLY2;
              tx_byte_d   = RSP_ERR;
              tx_valid_d  = 1'b1;
              err_reply_d = 1'b1;
              cmd_err_d   = 1'b1;
            end
          endcase
        end
      end

      ST_ARG: begin
        if (rx_valid) begin
          if (arg_ok) begin
            width_d     = arg_w;
            width_chg_d = (arg_w != width_q);
            state_d     = ST_IDLE;
          end else begin
            state_d     = ST_REPLY2;
            tx_byte_d   = RSP_ERR;
            tx_valid_d  = 1'b1;
            err_reply_d = 1'b1;
            cmd_err_d   = 1'b1;
          end
        end
`ifdef TRACE_CTRL_TIMEOUT_EN
        else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          cmd_err_d = 1'b1;
        end
`endif
      end

      ST_REPLY0: begin
        if (tx_done) begin
          state_d   = ST_REPLY1;
          tx_byte_d = ASCII_ZERO + {5'b0, width_q};
        end
      end

      ST_REPLY1: begin
        if (tx_done) begin
          state_d   = ST_REPLY2;
          tx_byte_d = 8'h00;
          tx_byte_d[FLAG_EN]    = trace_en_q;
          tx_byte_d[FLAG_DROP]  = drop_q | drop_set;
          tx_byte_d[FLAG_RXERR] = rxerr_q | rx_err;
        end
      end

      ST_REPLY2: begin
        if (tx_done) begin
          state_d    = ST_IDLE;
          tx_valid_d = 1'b0;
          sticky_clr = !err_reply_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A new event in the clearing cycle must survive, so set dominates clear.
    drop_d  = drop_set | (drop_q & ~sticky_clr);
    rxerr_d = rx_err   | (rxerr_q & ~sticky_clr);
  end

  always_comb begin
    hb_cnt_d = hb_cnt_q + HBW'(1);
    hb_d     = hb_q;
    if (hb_cnt_q == HBW'(HB_TC - 1)) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  always_ff @(posedge clkOut) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      width_q     <= 3'd1;
      trace_en_q  <= 1'b1;
      tx_byte_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      width_chg_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      err_reply_q <= 1'b0;
      drop_q      <= 1'b0;
      rxerr_q     <= 1'b0;
      hb_cnt_q    <= '0;
      hb_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      trace_en_q  <= trace_en_d;
      tx_byte_q   <= tx_byte_d;
      tx_valid_q  <= tx_valid_d;
      width_chg_q <= width_chg_d;
      cmd_err_q   <= cmd_err_d;
      err_reply_q <= err_reply_d;
      drop_q      <= drop_d;
      rxerr_q     <= rxerr_d;
      hb_cnt_q    <= hb_cnt_d;
      hb_q        <= hb_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_led
    led_stretch #(
      .STRETCH_CYCLES(STRETCH_CYCLES)
    ) u_led (
      .clkOut(clkOut),
      .rst   (rst),
      .evt   (led_evt[gi]),
      .led   (led_out[gi])
    );
  end

  assign tx_byte   = tx_byte_q;
  assign tx_valid  = tx_valid_q;
  assign width     = width_q;
  assign width_chg = width_chg_q;
  assign trace_en  = trace_en_q;
  assign cmd_err   = cmd_err_q;
  assign heartbeat = hb_q;

endmodule
